// File: rtl/m2v_coef_buf.sv
// m2v_coef_buf: two-bank coefficient buffer between inverse-scan/dequant and the IDCT.
// The writer pulls 64 sign-magnitude coefficients per block in raster order and stores
// them as saturated two's complement. The reader streams each block out column-major
// (or raster) with a valid/ready handshake. Two banks let one block fill while the
// other drains. OUT_W is expected to be in 2..13.
module m2v_coef_buf #(
  parameter int OUT_W     = 12,
  parameter bit TRANSPOSE = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             softreset,
  output logic             ready_buf,
  input  logic             blk_start,
  input  logic             blk_coded,
  input  logic             coef_sign,
  input  logic [11:0]      coef_data,
  output logic             coef_next,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_ZERO} wstate_e;
  typedef enum logic       {R_IDLE, R_SEND} rstate_e;

  localparam logic [12:0] POS_LIM = 13'((1 << (OUT_W - 1)) - 1);
  localparam logic [12:0] NEG_LIM = 13'(1 << (OUT_W - 1));

  // Both banks in one array, addressed {bank, index}
  logic [OUT_W-1:0] mem [128];

  wstate_e          wstate_q, wstate_d;
  logic             wbank_q, wbank_d;
  logic [5:0]       widx_q, widx_d;
  logic [1:0]       full_q, full_d;
  logic             old_q, old_d;
  rstate_e          rstate_q, rstate_d;
  logic             rbank_q, rbank_d;
  logic [5:0]       ridx_q, ridx_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             wr_en;
  logic [OUT_W-1:0] wr_data;
  logic             set_full;
  logic             clr_full;
  logic [OUT_W-1:0] conv;
  logic [12:0]      mag13;
  logic [12:0]      val13;
  logic             load;
  logic             ld_bank;
  logic [5:0]       ld_idx;

  function automatic logic [5:0] rd_addr(input logic [5:0] k);
    if (TRANSPOSE) return {k[2:0], k[5:3]};
    else           return k;
  endfunction

  assign ready_buf = (wstate_q == W_IDLE) && !(&full_q);
  assign coef_next = (wstate_q == W_FILL);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (ridx_q == 6'd63);

  // Sign-magnitude to saturated two's complement, 13-bit arithmetic before truncation
  always_comb begin
    mag13 = {1'b0, coef_data};
    val13 = '0;
    if (!coef_sign) val13 = (mag13 > POS_LIM) ? POS_LIM : mag13;
    else            val13 = 13'd0 - ((mag13 > NEG_LIM) ? NEG_LIM : mag13);
    conv = val13[OUT_W-1:0];
  end

  // Writer: pick an empty bank on blk_start, then write 64 words (pulled or zero)
  always_comb begin
    wstate_d = wstate_q;
    wbank_d  = wbank_q;
    widx_d   = widx_q;
    wr_en    = 1'b0;
    wr_data  = '0;
    set_full = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (blk_start && ready_buf) begin
          wstate_d = blk_coded ? W_FILL : W_ZERO;
          wbank_d  = full_q[0];
          widx_d   = '0;
        end
      end
      W_FILL, W_ZERO: begin
        wr_en   = 1'b1;
        wr_data = (wstate_q == W_FILL) ? conv : '0;
        widx_d  = widx_q + 6'd1;
        if (widx_q == 6'd63) begin
          set_full = 1'b1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reader: start on the oldest full bank, step on accept, chain to the other bank without a bubble
  always_comb begin
    rstate_d    = rstate_q;
    rbank_d     = rbank_q;
    ridx_d      = ridx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    clr_full    = 1'b0;
    load        = 1'b0;
    ld_bank     = rbank_q;
    ld_idx      = ridx_q;
    case (rstate_q)
      R_IDLE: begin
        if (|full_q) begin
          load    = 1'b1;
          ld_bank = full_q[old_q] ? old_q : ~old_q;
          ld_idx  = '0;
        end
      end
      R_SEND: begin
        if (out_valid_q && out_ready) begin
          if (ridx_q == 6'd63) begin
            clr_full = 1'b1;
            if (full_q[~rbank_q]) begin
              load    = 1'b1;
              ld_bank = ~rbank_q;
              ld_idx  = '0;
            end else begin
              rstate_d    = R_IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            load   = 1'b1;
            ld_idx = ridx_q + 6'd1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (load) begin
      rstate_d    = R_SEND;
      rbank_d     = ld_bank;
      ridx_d      = ld_idx;
      out_valid_d = 1'b1;
      out_data_d  = mem[{ld_bank, rd_addr(ld_idx)}];
    end
  end

  // Full flags and fill order. old_q names the bank filled first; a completed fill
  // only becomes oldest if the other bank is not still waiting to be read.
  always_comb begin
    full_d = full_q;
    old_d  = old_q;
    if (clr_full) begin
      full_d[rbank_q] = 1'b0;
      old_d           = ~rbank_q;
    end
    if (set_full) begin
      full_d[wbank_q] = 1'b1;
      if (!full_q[~wbank_q]) old_d = wbank_q;
    end
  end

  // State registers with async active-low reset and synchronous softreset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate_q    <= W_IDLE;
      wbank_q     <= 1'b0;
      widx_q      <= '0;
      full_q      <= '0;
      old_q       <= 1'b0;
      rstate_q    <= R_IDLE;
      rbank_q     <= 1'b0;
      ridx_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (softreset) begin
      wstate_q    <= W_IDLE;
      wbank_q     <= 1'b0;
      widx_q      <= '0;
      full_q      <= '0;
      old_q       <= 1'b0;
      rstate_q    <= R_IDLE;
      rbank_q     <= 1'b0;
      ridx_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wbank_q     <= wbank_d;
      widx_q      <= widx_d;
      full_q      <= full_d;
      old_q       <= old_d;
      rstate_q    <= rstate_d;
      rbank_q     <= rbank_d;
      ridx_q      <= ridx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bank storage write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank_q, widx_q}] <= wr_data;
  end

endmodule

// File: tb/tb_m2v_coef_buf.sv
// Self-checking bench for m2v_coef_buf: randomized blocks against a queue-based model
// that tracks bank occupancy, fill timing and the expected transposed output stream.
module tb_m2v_coef_buf;
  localparam int OUT_W = 12;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             softreset;
  logic             ready_buf;
  logic             blk_start;
  logic             blk_coded;
  logic             coef_sign;
  logic [11:0]      coef_data;
  logic             coef_next;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  m2v_coef_buf #(.OUT_W(OUT_W), .TRANSPOSE(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .softreset (softreset),
    .ready_buf (ready_buf),
    .blk_start (blk_start),
    .blk_coded (blk_coded),
    .coef_sign (coef_sign),
    .coef_data (coef_data),
    .coef_next (coef_next),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {int data; bit last;} exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int busy    = 0;   // fill cycles left in the current block
  int pending = 0;   // blocks accepted and not fully output (= banks in use)
  bit cur_coded = 0;
  bit cur_sign[64];
  int cur_mag[64];
  bit nxt_sign[64];
  int nxt_mag[64];

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input bit s, input int m);
    if (!s) return (m > 2047) ? 2047 : m;
    return -((m > 2048) ? 2048 : m);
  endfunction

  // Per-cycle check and model update, run on the falling edge
  task automatic monitor();
    bit   rdy;
    exp_t e;
    int   r;
    rdy = (busy == 0) && (pending < 2);
    check("ready_buf", int'(ready_buf), int'(rdy));
    check("coef_next", int'(coef_next), int'(busy > 0 && cur_coded));
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_word", int'(out_valid), 0);
      else begin
        e = exp_q[0];
        check("out_data", int'($signed(out_data)), e.data);
        check("out_last", int'(out_last), int'(e.last));
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e.last) pending--;
        end
      end
    end else begin
      check("out_last_idle", int'(out_last), 0);
    end
    if (busy > 0) begin
      coef_sign = cur_sign[64-busy];
      coef_data = 12'(cur_mag[64-busy]);
      busy--;
    end
    if (blk_start && rdy) begin
      for (int i = 0; i < 64; i++) begin
        cur_sign[i] = nxt_sign[i];
        cur_mag[i]  = nxt_mag[i];
      end
      cur_coded = blk_coded;
      busy      = 64;
      pending++;
      for (int k = 0; k < 64; k++) begin
        r      = (k % 8) * 8 + k / 8;
        e.data = blk_coded ? sat(nxt_sign[r], nxt_mag[r]) : 0;
        e.last = (k == 63);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    blk_start = 1'b0;
  endtask

  task automatic pulse(input bit coded);
    blk_coded = coded;
    blk_start = 1'b1;
    step();
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    while ((exp_q.size() != 0 || busy != 0) && n < 2000) begin
      if (toggle) out_ready = ~out_ready;
      step();
      n++;
    end
    check("drain_timeout", exp_q.size() + busy, 0);
    out_ready = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(busy == 0 && pending < 2) && n < 1000) begin
      step();
      n++;
    end
    check("wait_ready_timeout", int'(busy == 0 && pending < 2), 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      nxt_sign[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) nxt_mag[i] = int'($urandom_range(2040, 4095));
      else                           nxt_mag[i] = int'($urandom_range(0, 2100));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_coef_next", int'(coef_next), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last",  int'(out_last), 0);
    check("rst_out_data",  int'(out_data), 0);
    exp_q.delete();
    busy      = 0;
    pending   = 0;
    cur_coded = 1'b0;
    blk_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_buf", int'(ready_buf), 1);
  endtask

  initial begin
    reset_n   = 1'b1;
    softreset = 1'b0;
    blk_start = 1'b0;
    blk_coded = 1'b0;
    coef_sign = 1'b0;
    coef_data = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Ramp block: magnitude equals raster index
    for (int i = 0; i < 64; i++) begin
      nxt_sign[i] = 1'b0;
      nxt_mag[i]  = i;
    end
    pulse(1'b1);
    drain(1'b0);

    // Saturation corners
    fill_rand();
    nxt_sign[0] = 1'b0; nxt_mag[0] = 4095;
    nxt_sign[1] = 1'b1; nxt_mag[1] = 4095;
    nxt_sign[2] = 1'b1; nxt_mag[2] = 2048;
    nxt_sign[3] = 1'b0; nxt_mag[3] = 2047;
    nxt_sign[4] = 1'b1; nxt_mag[4] = 0;
    pulse(1'b1);
    drain(1'b0);

    // Uncoded block
    fill_rand();
    pulse(1'b0);
    drain(1'b0);

    // Back-to-back with output stalled: two buffered, third ignored
    out_ready = 1'b0;
    fill_rand();
    wait_ready();
    pulse(1'b1);
    wait_ready();
    fill_rand();
    pulse(1'b1);
    repeat (70) step();
    check("b2b_ready_low", int'(ready_buf), 0);
    fill_rand();
    pulse(1'b1);
    out_ready = 1'b1;
    for (int j = 0; j < 128; j++) begin
      check("b2b_contig", int'(out_valid), 1);
      step();
    end
    drain(1'b0);

    // Backpressure: toggle out_ready every cycle
    fill_rand();
    pulse(1'b1);
    drain(1'b1);

    // Reset at fill index 30, then a normal block
    fill_rand();
    pulse(1'b1);
    repeat (30) step();
    do_reset();
    fill_rand();
    pulse(1'b1);
    drain(1'b0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        fill_rand();
        blk_coded = 1'($urandom_range(0, 1));
        blk_start = 1'b1;
      end
      step();
    end
    out_ready = 1'b1;
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
